// File: rtl/fp_divider_iter.sv
`default_nettype none
// ============================================================================
// Module      : fp_divider_iter
// Description : Iterative single-precision divider, one quotient bit per clock
//               (radix-2 restoring), start/done handshake. Build option
//               FPDIV_ROUND_EN selects round-to-nearest-even; otherwise the
//               quotient is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_divider_iter #(
    parameter int D_WIDTH = 32,
    parameter int E_WIDTH = 8,
    parameter int M_WIDTH = 23,
    parameter int Q_BITS  = 26
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [D_WIDTH-1:0] floating1_in,
    input  logic [D_WIDTH-1:0] floating2_in,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] floating_division_out
);
    localparam int c_sig_w = M_WIDTH + 1;
    localparam int c_rem_w = M_WIDTH + 2;
    localparam int c_exp_w = E_WIDTH + 2;
    localparam int c_cnt_w = $clog2(Q_BITS);

    localparam logic [E_WIDTH-1:0]        c_exp_max  = '1;
    localparam logic signed [c_exp_w-1:0] c_exp_inf  = c_exp_w'((1 << E_WIDTH) - 1);
    localparam logic signed [c_exp_w-1:0] c_bias     = c_exp_w'((1 << (E_WIDTH - 1)) - 1);
    localparam logic [c_cnt_w-1:0]        c_cnt_last = c_cnt_w'(Q_BITS - 1);
    localparam logic [D_WIDTH-1:0]        c_qnan     = {1'b0, c_exp_max, 1'b1, {(M_WIDTH-1){1'b0}}};

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_divide = 2'd1;
    localparam logic [1:0] c_st_norm   = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    logic [1:0]                r_state, w_state_next;
    logic                      r_sign, r_special, r_busy, r_done;
    logic signed [c_exp_w-1:0] r_exp;
    logic [c_rem_w-1:0]        r_rem;
    logic [c_sig_w-1:0]        r_div;
    logic [Q_BITS-1:0]         r_q;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [D_WIDTH-1:0]        r_special_val, r_result;

    // Operand classification; an exponent field of zero is treated as zero.
    logic [E_WIDTH-1:0] w_a_exp, w_b_exp;
    logic [M_WIDTH-1:0] w_a_man, w_b_man;
    logic w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_sign;
    logic w_special;
    logic [D_WIDTH-1:0] w_special_val;

    assign w_a_exp  = floating1_in[D_WIDTH-2 -: E_WIDTH];
    assign w_b_exp  = floating2_in[D_WIDTH-2 -: E_WIDTH];
    assign w_a_man  = floating1_in[M_WIDTH-1:0];
    assign w_b_man  = floating2_in[M_WIDTH-1:0];
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_inf  = (w_a_exp == c_exp_max) && (w_a_man == '0);
    assign w_b_inf  = (w_b_exp == c_exp_max) && (w_b_man == '0);
    assign w_a_nan  = (w_a_exp == c_exp_max) && (w_a_man != '0);
    assign w_b_nan  = (w_b_exp == c_exp_max) && (w_b_man != '0);
    assign w_sign   = floating1_in[D_WIDTH-1] ^ floating2_in[D_WIDTH-1];

    always_comb begin
        w_special     = 1'b1;
        w_special_val = '0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_special_val = c_qnan;
        end else if (w_a_inf || w_b_zero) begin
            w_special_val = {w_sign, c_exp_max, {M_WIDTH{1'b0}}};
        end else if (w_a_zero || w_b_inf) begin
            w_special_val = {w_sign, {(D_WIDTH-1){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    // One restoring step; the remainder always stays below twice the divisor.
    logic [c_rem_w:0]   w_trial;
    logic               w_trial_neg;
    logic [c_rem_w-1:0] w_rem_sel;

    assign w_trial     = {1'b0, r_rem} - {2'b00, r_div};
    assign w_trial_neg = w_trial[c_rem_w];
    assign w_rem_sel   = w_trial_neg ? r_rem : w_trial[c_rem_w-1:0];

    // Normalisation, rounding and range check of the finished quotient.
    logic [Q_BITS-1:0]         w_q_norm;
    logic signed [c_exp_w-1:0] w_exp_norm, w_exp_rnd;
    logic [M_WIDTH-1:0]        w_man, w_man_rnd;
    logic                      w_guard, w_round, w_sticky, w_round_up, w_carry;
    logic [D_WIDTH-1:0]        w_norm_result;

    assign w_q_norm   = r_q[Q_BITS-1] ? r_q : {r_q[Q_BITS-2:0], 1'b0};
    assign w_exp_norm = r_q[Q_BITS-1] ? r_exp : r_exp - c_exp_w'(1);
    assign w_man      = w_q_norm[Q_BITS-2 -: M_WIDTH];
    assign w_guard    = w_q_norm[1];
    assign w_round    = w_q_norm[0];
    assign w_sticky   = |r_rem;

`ifdef FPDIV_ROUND_EN
    assign w_round_up = w_guard & (w_round | w_sticky | w_man[0]);
`else
    logic w_unused_grs;
    assign w_unused_grs = w_guard ^ w_round ^ w_sticky;
    assign w_round_up   = 1'b0;
`endif

    assign {w_carry, w_man_rnd} = {1'b0, w_man} + (M_WIDTH+1)'(w_round_up);
    assign w_exp_rnd = w_exp_norm + c_exp_w'(w_carry);

    always_comb begin
        w_norm_result = {r_sign, w_exp_rnd[E_WIDTH-1:0], w_man_rnd};
        if (r_special) begin
            w_norm_result = r_special_val;
        end else if (w_exp_rnd >= c_exp_inf) begin
            w_norm_result = {r_sign, c_exp_max, {M_WIDTH{1'b0}}};
        end else if (w_exp_rnd <= 0) begin
            w_norm_result = {r_sign, {(D_WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (start) w_state_next = c_st_divide;
            c_st_divide: if (r_cnt == c_cnt_last) w_state_next = c_st_norm;
            c_st_norm:   w_state_next = c_st_done;
            default:     w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign        <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_exp         <= '0;
            r_rem         <= '0;
            r_div         <= '0;
            r_q           <= '0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_sign        <= w_sign;
                        r_special     <= w_special;
                        r_special_val <= w_special_val;
                        r_exp         <= c_exp_w'(w_a_exp) - c_exp_w'(w_b_exp) + c_bias;
                        r_rem         <= {1'b0, 1'b1, w_a_man};
                        r_div         <= {1'b1, w_b_man};
                        r_q           <= '0;
                        r_cnt         <= '0;
                        r_busy        <= 1'b1;
                    end
                end
                c_st_divide: begin
                    r_q   <= {r_q[Q_BITS-2:0], ~w_trial_neg};
                    r_rem <= {w_rem_sel[c_rem_w-2:0], 1'b0};
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
                c_st_norm: begin
                    r_result <= w_norm_result;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign busy                  = r_busy;
    assign done                  = r_done;
    assign floating_division_out = r_result;

endmodule
`default_nettype wire
